zip_skidfifo: RTL and testbench

//  Parametrised multi-entry elastic buffer for valid/ready streams; successor to the 2-entry skid buffer.

---
 rtl/zip_skidfifo.sv | 133 +++++++++++++
 tb/tb_zip_skidfifo.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zip_skidfifo.sv
// Multi-entry elastic buffer for valid/ready streams with an optional registered output stage.
// Define ZIP_SKIDFIFO_FLUSH_EN to add the synchronous i_flush input.
module zip_skidfifo #(
  parameter int DW           = 8,
  parameter int DEPTH        = 4,
  parameter int OPT_OUTREG   = 1,
  parameter int OPT_LOWPOWER = 0,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
`ifdef ZIP_SKIDFIFO_FLUSH_EN
  input  logic                     i_flush,
`endif
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [DW-1:0]            i_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DW-1:0]            o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_almost_full
);

  localparam int LGDEPTH = $clog2(DEPTH);
  localparam int CAP     = DEPTH + ((OPT_OUTREG != 0) ? 1 : 0);
  localparam logic [LGDEPTH:0] CAP_W   = CAP[LGDEPTH:0];
  localparam logic [LGDEPTH:0] AFULL_W = AFULL_THRESH[LGDEPTH:0];
  localparam logic [LGDEPTH:0] ONE     = {{LGDEPTH{1'b0}}, 1'b1};

  logic [DW-1:0]    mem [DEPTH];
  logic [LGDEPTH:0] rd_ptr, wr_ptr, count_nxt;
  logic             ready_r, flush, push, pop;
  logic             store_empty, store_full, store_wr, store_rd;

`ifdef ZIP_SKIDFIFO_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  // Flush masks o_ready immediately; the registered part never sees i_ready.
  assign o_ready     = ready_r && !flush;
  assign push        = i_valid && o_ready;
  assign pop         = o_valid && i_ready;
  assign store_empty = (rd_ptr == wr_ptr);
  assign store_full  = (rd_ptr[LGDEPTH] != wr_ptr[LGDEPTH]) &&
                       (rd_ptr[LGDEPTH-1:0] == wr_ptr[LGDEPTH-1:0]);

  always_comb begin
    count_nxt = o_count;
    if (push && !pop)
      count_nxt = o_count + ONE;
    else if (pop && !push)
      count_nxt = o_count - ONE;
  end

  generate
    if (OPT_OUTREG != 0) begin : g_outreg
      logic          out_valid;
      logic [DW-1:0] out_data;
      logic          load;

      assign load     = !out_valid || i_ready;
      assign store_rd = load && !store_empty;
      // An empty store with a free output stage lets the push bypass the store.
      assign store_wr = push && !(load && store_empty) && !store_full;

      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          out_valid <= 1'b0;
          out_data  <= '0;
        end else if (flush) begin
          out_valid <= 1'b0;
          if (OPT_LOWPOWER != 0)
            out_data <= '0;
        end else if (load) begin
          if (!store_empty) begin
            out_valid <= 1'b1;
            out_data  <= mem[rd_ptr[LGDEPTH-1:0]];
          end else if (push) begin
            out_valid <= 1'b1;
            out_data  <= i_data;
          end else begin
            out_valid <= 1'b0;
            if (OPT_LOWPOWER != 0)
              out_data <= '0;
          end
        end
      end

      assign o_valid = out_valid;
      assign o_data  = out_data;
    end else begin : g_fallthru
      assign store_rd = pop && !store_empty;
      assign store_wr = push && !(pop && store_empty) && !store_full;
      assign o_valid  = !store_empty || push;
      // Data path is combinational here, so reset and low-power zeroing are gated on o_valid.
      assign o_data   = (!o_valid && ((OPT_LOWPOWER != 0) || !i_reset_n)) ? '0 :
                        (store_empty ? i_data : mem[rd_ptr[LGDEPTH-1:0]]);
    end
  endgenerate

  // Store write port: data only, not reset.
  always_ff @(posedge i_clk) begin
    if (store_wr)
      mem[wr_ptr[LGDEPTH-1:0]] <= i_data;
  end

  // Pointers, occupancy and registered flow-control flags.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      o_count       <= '0;
      ready_r       <= 1'b0;
      o_almost_full <= 1'b0;
    end else if (flush) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      o_count       <= '0;
      ready_r       <= 1'b1;
      o_almost_full <= 1'b0;
    end else begin
      rd_ptr        <= rd_ptr + (store_rd ? ONE : '0);
      wr_ptr        <= wr_ptr + (store_wr ? ONE : '0);
      o_count       <= count_nxt;
      ready_r       <= (count_nxt < CAP_W);
      o_almost_full <= (count_nxt >= AFULL_W);
    end
  end

endmodule

// File: tb/tb_zip_skidfifo.sv
// Scoreboard bench for zip_skidfifo: one registered-output instance and one fall-through instance.
module tb_zip_skidfifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         total = 0;
  int         bad = 0;

  logic       a_valid = 0, a_ready, a_ovalid, a_iready = 0, a_afull;
  logic [7:0] a_data = 0, a_odata;
  logic [2:0] a_count;
  logic       b_valid = 0, b_ready, b_ovalid, b_iready = 0, b_afull;
  logic [7:0] b_data = 0, b_odata;
  logic [2:0] b_count;
`ifdef ZIP_SKIDFIFO_FLUSH_EN
  logic       a_flush = 0, b_flush = 0;
`endif

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  always #5 clk = ~clk;

  zip_skidfifo #(.DW(8), .DEPTH(4), .OPT_OUTREG(1), .OPT_LOWPOWER(0)) u_reg (
    .i_clk(clk), .i_reset_n(rst_n),
`ifdef ZIP_SKIDFIFO_FLUSH_EN
    .i_flush(a_flush),
`endif
    .i_valid(a_valid), .o_ready(a_ready), .i_data(a_data),
    .o_valid(a_ovalid), .i_ready(a_iready), .o_data(a_odata),
    .o_count(a_count), .o_almost_full(a_afull));

  zip_skidfifo #(.DW(8), .DEPTH(4), .OPT_OUTREG(0), .OPT_LOWPOWER(1)) u_ft (
    .i_clk(clk), .i_reset_n(rst_n),
`ifdef ZIP_SKIDFIFO_FLUSH_EN
    .i_flush(b_flush),
`endif
    .i_valid(b_valid), .o_ready(b_ready), .i_data(b_data),
    .o_valid(b_ovalid), .i_ready(b_iready), .o_data(b_odata),
    .o_count(b_count), .o_almost_full(b_afull));

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); #1;
    total++;
    if ({a_ovalid, a_ready, a_count, a_afull, a_odata} !== 14'h0) begin
      bad++; $display("FAIL reset_a: got v=%b r=%b c=%0d af=%b d=%h want all 0", a_ovalid, a_ready, a_count, a_afull, a_odata);
    end
    total++;
    if ({b_ovalid, b_ready, b_count, b_afull, b_odata} !== 14'h0) begin
      bad++; $display("FAIL reset_b: got v=%b r=%b c=%0d af=%b d=%h want all 0", b_ovalid, b_ready, b_count, b_afull, b_odata);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    total++;
    if ({a_ready, b_ready} !== 2'b11) begin
      bad++; $display("FAIL ready_after_reset: got a=%b b=%b want 1 1", a_ready, b_ready);
    end
    @(negedge clk);
  endtask

  // Scenario: five pushes into the registered instance with the sink stalled.
  task automatic test_fill_stall();
    int n;
    for (int k = 0; k < 6; k++) begin
      a_valid = (k < 5); a_data = 8'(k + 1); a_iready = 1'b0;
      #1;
      n = qa.size();
      total++;
      if ({a_count, a_ready, a_afull} !== {n[2:0], n < 5, n >= 3}) begin
        bad++; $display("FAIL fill_status: got c=%0d r=%b af=%b want c=%0d", a_count, a_ready, a_afull, n);
      end
      if (k >= 1) begin
        total++;
        if (a_ovalid !== 1'b1 || a_odata !== 8'h01) begin
          bad++; $display("FAIL stall_hold: got v=%b d=%h want 1 01", a_ovalid, a_odata);
        end
      end
      if (a_valid && a_ready) qa.push_back(a_data);
      @(negedge clk);
    end
    a_valid = 1'b0; #1;
    total++;
    if ({a_count, a_ready, a_afull, a_odata} !== {3'd5, 1'b0, 1'b1, 8'h01}) begin
      bad++; $display("FAIL fill_final: got c=%0d r=%b af=%b d=%h want 5 0 1 01", a_count, a_ready, a_afull, a_odata);
    end
  endtask

  // Scenario: drain the full registered instance.
  task automatic test_drain();
    logic [7:0] exp;
    int n;
    for (int k = 0; k < 6; k++) begin
      a_valid = 1'b0; a_iready = 1'b1;
      #1;
      n = qa.size();
      total++;
      if ({a_count, a_ready, a_afull} !== {3'(5 - k), k >= 1, k <= 2}) begin
        bad++; $display("FAIL drain_status: got c=%0d r=%b af=%b want c=%0d", a_count, a_ready, a_afull, 5 - k);
      end
      if (a_ovalid && a_iready) begin
        total++;
        if (n == 0) begin
          bad++; $display("FAIL drain_order: got %h want none", a_odata);
        end else begin
          exp = qa.pop_front();
          if (a_odata !== exp || exp !== 8'(k + 1)) begin
            bad++; $display("FAIL drain_order: got %h want %h", a_odata, 8'(k + 1));
          end
        end
      end
      @(negedge clk);
    end
    total++;
    if (a_ovalid !== 1'b0 || qa.size() != 0) begin
      bad++; $display("FAIL drain_empty: got v=%b left=%0d want 0 0", a_ovalid, qa.size());
    end
  endtask

  // Scenario: continuous streaming through the registered instance.
  task automatic test_stream();
    logic [7:0] exp;
    for (int k = 0; k < 23; k++) begin
      a_valid = (k < 20); a_data = 8'(8'h10 + k); a_iready = 1'b1;
      #1;
      if (k >= 1 && k <= 20) begin
        total++;
        if (a_count !== 3'd1 || a_ovalid !== 1'b1) begin
          bad++; $display("FAIL stream_steady: got c=%0d v=%b want 1 1", a_count, a_ovalid);
        end
      end
      if (a_ovalid && a_iready) begin
        total++;
        if (qa.size() == 0) begin
          bad++; $display("FAIL stream_order: got %h want none", a_odata);
        end else begin
          exp = qa.pop_front();
          if (a_odata !== exp) begin
            bad++; $display("FAIL stream_order: got %h want %h", a_odata, exp);
          end
        end
      end
      if (a_valid && a_ready) qa.push_back(a_data);
      @(negedge clk);
    end
  endtask

  // Scenario: random traffic on the registered instance, with stall and ready-path checks.
  task automatic test_random_reg(input int cycles);
    logic [7:0] exp, d, held_d;
    logic held_v, r0;
    int n;
    d = 8'h40; held_v = 1'b0; held_d = '0;
    for (int k = 0; k < cycles; k++) begin
      a_valid  = (k < cycles - 8) && ($urandom_range(0, 3) != 0);
      a_data   = d;
      a_iready = (k >= cycles - 8) || ($urandom_range(0, 2) != 0);
      #1;
      n = qa.size();
      total++;
      if ({a_count, a_ready, a_afull} !== {n[2:0], n < 5, n >= 3}) begin
        bad++; $display("FAIL rand_a_status: got c=%0d r=%b af=%b want c=%0d", a_count, a_ready, a_afull, n);
      end
      if (held_v) begin
        total++;
        if (a_ovalid !== 1'b1 || a_odata !== held_d) begin
          bad++; $display("FAIL rand_a_stall: got v=%b d=%h want 1 %h", a_ovalid, a_odata, held_d);
        end
      end
      r0 = a_ready; a_iready = ~a_iready; #1;
      total++;
      if (a_ready !== r0) begin
        bad++; $display("FAIL ready_comb_path: got %b want %b", a_ready, r0);
      end
      a_iready = ~a_iready; #1;
      if (a_ovalid && a_iready) begin
        total++;
        if (n == 0) begin
          bad++; $display("FAIL rand_a_order: got %h want none", a_odata);
        end else begin
          exp = qa.pop_front();
          if (a_odata !== exp) begin
            bad++; $display("FAIL rand_a_order: got %h want %h", a_odata, exp);
          end
        end
      end
      if (a_valid && a_ready) begin qa.push_back(a_data); d++; end
      held_v = a_ovalid && !a_iready; held_d = a_odata;
      @(negedge clk);
    end
    total++;
    if (qa.size() != 0 || a_ovalid !== 1'b0) begin
      bad++; $display("FAIL rand_a_drain: got left=%0d v=%b want 0 0", qa.size(), a_ovalid);
    end
  endtask

  // Scenario: same-cycle bypass on the empty fall-through instance.
  task automatic test_bypass();
    b_valid = 1'b1; b_data = 8'hA5; b_iready = 1'b1;
    #1;
    total++;
    if (b_ovalid !== 1'b1 || b_odata !== 8'hA5) begin
      bad++; $display("FAIL bypass_same_cycle: got v=%b d=%h want 1 a5", b_ovalid, b_odata);
    end
    @(negedge clk);
    b_valid = 1'b0; #1;
    total++;
    if (b_count !== 3'd0 || b_ovalid !== 1'b0 || b_odata !== 8'h00) begin
      bad++; $display("FAIL bypass_count: got c=%0d v=%b d=%h want 0 0 00", b_count, b_ovalid, b_odata);
    end
  endtask

  // Scenario: random traffic on the fall-through instance.
  task automatic test_random_ft(input int cycles);
    logic [7:0] exp, d;
    int n;
    d = 8'h80;
    for (int k = 0; k < cycles; k++) begin
      b_valid  = (k < cycles - 6) && ($urandom_range(0, 3) != 0);
      b_data   = d;
      b_iready = (k >= cycles - 6) || ($urandom_range(0, 2) != 0);
      #1;
      n = qb.size();
      total++;
      if ({b_count, b_ready, b_afull} !== {n[2:0], n < 4, n >= 3}) begin
        bad++; $display("FAIL rand_b_status: got c=%0d r=%b af=%b want c=%0d", b_count, b_ready, b_afull, n);
      end
      if (b_valid && b_ready) begin qb.push_back(b_data); d++; end
      if (b_ovalid && b_iready) begin
        total++;
        if (qb.size() == 0) begin
          bad++; $display("FAIL rand_b_order: got %h want none", b_odata);
        end else begin
          exp = qb.pop_front();
          if (b_odata !== exp) begin
            bad++; $display("FAIL rand_b_order: got %h want %h", b_odata, exp);
          end
        end
      end
      @(negedge clk);
    end
    total++;
    if (qb.size() != 0 || b_ovalid !== 1'b0) begin
      bad++; $display("FAIL rand_b_drain: got left=%0d v=%b want 0 0", qb.size(), b_ovalid);
    end
  endtask

  // Scenario: asynchronous reset with three words held.
  task automatic test_midreset();
    for (int k = 0; k < 3; k++) begin
      a_valid = 1'b1; a_data = 8'(8'h61 + k); a_iready = 1'b0;
      @(negedge clk);
    end
    a_valid = 1'b0; #1;
    total++;
    if (a_count !== 3'd3) begin
      bad++; $display("FAIL midreset_pre: got c=%0d want 3", a_count);
    end
    #1 rst_n = 1'b0; #1;
    total++;
    if (a_ovalid !== 1'b0 || a_count !== 3'd0 || a_ready !== 1'b0) begin
      bad++; $display("FAIL midreset_clear: got v=%b c=%0d r=%b want 0 0 0", a_ovalid, a_count, a_ready);
    end
    qa.delete(); qb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_valid = 1'b1; a_data = 8'h77; a_iready = 1'b1; #1;
    total++;
    if (a_ready !== 1'b1) begin
      bad++; $display("FAIL midreset_ready: got %b want 1", a_ready);
    end
    @(negedge clk);
    a_valid = 1'b0; #1;
    total++;
    if (a_ovalid !== 1'b1 || a_odata !== 8'h77) begin
      bad++; $display("FAIL midreset_first: got v=%b d=%h want 1 77", a_ovalid, a_odata);
    end
    @(negedge clk);
  endtask

`ifdef ZIP_SKIDFIFO_FLUSH_EN
  // Scenario: flush while three words are held and a push is offered.
  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      a_valid = 1'b1; a_data = 8'(8'h31 + k); a_iready = 1'b0;
      @(negedge clk);
    end
    a_flush = 1'b1; a_valid = 1'b1; a_data = 8'hEE; #1;
    total++;
    if (a_ready !== 1'b0) begin
      bad++; $display("FAIL flush_refuse: got r=%b want 0", a_ready);
    end
    @(negedge clk);
    a_flush = 1'b0; a_valid = 1'b0; #1;
    total++;
    if (a_ovalid !== 1'b0 || a_count !== 3'd0 || a_afull !== 1'b0) begin
      bad++; $display("FAIL flush_clear: got v=%b c=%0d af=%b want 0 0 0", a_ovalid, a_count, a_afull);
    end
    a_valid = 1'b1; a_data = 8'h99; a_iready = 1'b1;
    @(negedge clk);
    a_valid = 1'b0; #1;
    total++;
    if (a_ovalid !== 1'b1 || a_odata !== 8'h99) begin
      bad++; $display("FAIL flush_next: got v=%b d=%h want 1 99", a_ovalid, a_odata);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_fill_stall();
    test_drain();
    test_stream();
    test_random_reg(300);
    test_bypass();
    test_random_ft(300);
    test_midreset();
`ifdef ZIP_SKIDFIFO_FLUSH_EN
    test_flush();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
